// File: rtl/round_pkg.sv
// round_pkg: shared definitions for the requantisation pipeline.
//   - Rounding-mode encodings carried on in_mode.
//   - round_inc(): +1 decision for a given mode from the dropped-bit summary.
package round_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'b00;  // floor
  localparam logic [1:0] RND_HALF_UP   = 2'b01;  // ties toward +inf
  localparam logic [1:0] RND_HALF_EVEN = 2'b10;  // ties to even quotient
  localparam logic [1:0] RND_HALF_AWAY = 2'b11;  // ties away from zero

  // half  : MSB of the dropped fraction (value >= 0.5 of an LSB)
  // rest  : OR of the dropped bits below half (strictly above the tie point)
  // q_lsb : LSB of the floored quotient (odd/even for ties)
  // sign  : sign of the original value
  function automatic logic round_inc(input logic [1:0] mode,
                                     input logic       half,
                                     input logic       rest,
                                     input logic       q_lsb,
                                     input logic       sign);
    logic inc;
    inc = 1'b0;
    case (mode)
      RND_TRUNC:     inc = 1'b0;
      RND_HALF_UP:   inc = half;
      RND_HALF_EVEN: inc = half & (rest | q_lsb);
      default:       inc = half & (rest | ~sign);  // RND_HALF_AWAY
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/round_sat.sv
// round_sat: combinational sum-and-clip.
//   q    in  QW     floored signed quotient
//   inc  in  1      rounding increment
//   data out OUT_W  q+inc clipped to signed OUT_W
//   sat  out 1      clipping occurred
module round_sat
  import round_pkg::*;
#(
  parameter int QW    = 12,
  parameter int OUT_W = 8
) (
  input  logic [QW-1:0]    q,
  input  logic             inc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  // One extra bit so q+inc can never overflow.
  localparam int SW = QW + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;  // -2^(OUT_W-1)

  logic signed [SW-1:0] sum;

  always_comb begin
    sum  = $signed({q[QW-1], q}) + $signed({{QW{1'b0}}, inc});
    data = sum[OUT_W-1:0];
    sat  = 1'b0;
    if (sum > MAX_V) begin
      data = {1'b0, {(OUT_W-1){1'b1}}};
      sat  = 1'b1;
    end else if (sum < MIN_V) begin
      data = {1'b1, {(OUT_W-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/round_requant_pipe.sv
// round_requant_pipe: drops SHIFT fractional LSBs from a signed IN_W value,
// rounds in a run-time-selected mode and saturates to signed OUT_W.
// Two-stage pipeline, valid/ready on both sides, no skid buffer.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data (IN_W), in_mode (2)
//   out_valid/out_ready output handshake; out_data (OUT_W), out_sat
//   sat_count (16)      saturation event counter, sat_cnt_clr clears it
// Optional macro ROUND_SAT_CNT_EN enables the counter; otherwise sat_count=0
// and sat_cnt_clr is ignored.
module round_requant_pipe
  import round_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [15:0]      sat_count,
  input  logic             sat_cnt_clr
);

  localparam int QW = IN_W - SHIFT;

  // Stage 1: floored quotient plus a summary of the dropped bits.
  logic            s1_valid_q, s1_valid_d;
  logic [QW-1:0]   s1_quo_q,   s1_quo_d;
  logic            s1_sign_q,  s1_sign_d;
  logic            s1_half_q,  s1_half_d;
  logic            s1_rest_q,  s1_rest_d;
  logic [1:0]      s1_mode_q,  s1_mode_d;

  // Stage 2: final rounded, clipped result.
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q,  s2_data_d;
  logic             s2_sat_q,   s2_sat_d;

  logic adv1, adv2;
  logic in_rest;
  logic s1_inc;
  logic [OUT_W-1:0] rs_data;
  logic rs_sat;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  generate
    if (SHIFT > 1) begin : g_rest
      assign in_rest = |in_data[SHIFT-2:0];
    end else begin : g_no_rest
      assign in_rest = 1'b0;
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_quo_d   = s1_quo_q;
    s1_sign_d  = s1_sign_q;
    s1_half_d  = s1_half_q;
    s1_rest_d  = s1_rest_q;
    s1_mode_d  = s1_mode_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        // Upper bits are exactly the arithmetic shift right by SHIFT.
        s1_quo_d  = in_data[IN_W-1:SHIFT];
        s1_sign_d = in_data[IN_W-1];
        s1_half_d = in_data[SHIFT-1];
        s1_rest_d = in_rest;
        s1_mode_d = in_mode;
      end
    end
  end

  assign s1_inc = round_inc(s1_mode_q, s1_half_q, s1_rest_q, s1_quo_q[0], s1_sign_q);

  round_sat #(.QW(QW), .OUT_W(OUT_W)) u_round_sat (
    .q    (s1_quo_q),
    .inc  (s1_inc),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = rs_data;
        s2_sat_d  = rs_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_quo_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_half_q  <= 1'b0;
      s1_rest_q  <= 1'b0;
      s1_mode_q  <= RND_TRUNC;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_quo_q   <= s1_quo_d;
      s1_sign_q  <= s1_sign_d;
      s1_half_q  <= s1_half_d;
      s1_rest_q  <= s1_rest_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;

`ifdef ROUND_SAT_CNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_cnt_clr) begin
      sat_count_d = '0;
    end else if (out_valid && out_ready && out_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  logic unused_sat_cnt_clr;
  assign unused_sat_cnt_clr = sat_cnt_clr;
  assign sat_count = '0;
`endif

endmodule
